// File: rtl/traffic_ctrl_n.sv
// traffic_ctrl_n: N-phase signal controller with pedestrian service,
// night flash mode and a one-second tick divider.
module traffic_ctrl_n #(
  parameter int FPGAFREQ = 50_000_000,
  parameter int NPHASES = 2,
  parameter int T_GREEN = 10,
  parameter int T_GREEN0 = 18,
  parameter int T_YELLOW = 4,
  parameter int T_ALLRED = 1,
  parameter int T_PEDWALK = 5,
  parameter int T_PEDCLEAR = 3,
  parameter int T_RESET = 3,
  localparam int PW = $clog2(NPHASES),
  localparam int M1 = T_GREEN > T_GREEN0 ? T_GREEN : T_GREEN0,
  localparam int M2 = M1 > T_YELLOW ? M1 : T_YELLOW,
  localparam int M3 = M2 > T_ALLRED ? M2 : T_ALLRED,
  localparam int M4 = M3 > T_PEDWALK ? M3 : T_PEDWALK,
  localparam int M5 = M4 > T_PEDCLEAR ? M4 : T_PEDCLEAR,
  localparam int TMAX = M5 > T_RESET ? M5 : T_RESET,
  localparam int SW = $clog2(TMAX + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ped_req,
  input  logic               flash_en,
  output logic [NPHASES-1:0] phase_red,
  output logic [NPHASES-1:0] phase_yellow,
  output logic [NPHASES-1:0] phase_green,
  output logic               ped_walk,
  output logic               ped_dontwalk,
  output logic               req_pending,
  output logic [PW-1:0]      cur_phase,
  output logic [SW-1:0]      sec_left
);

  typedef enum logic [2:0] {
    S_RESET,
    S_GREEN,
    S_YELLOW,
    S_ALLRED,
    S_PEDWALK,
    S_PEDCLEAR,
    S_FLASH
  } state_t;

  localparam int DW = FPGAFREQ > 1 ? $clog2(FPGAFREQ) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(FPGAFREQ - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(FPGAFREQ / 2);
  localparam logic [PW-1:0] LAST_PH = PW'(NPHASES - 1);

  state_t state;
  logic [DW-1:0] div;
  logic [2:0] sync;
  logic tick;
  logic expire;
  logic half;
  logic rise;
  logic ped_set;
  logic [NPHASES-1:0] onehot;

  function automatic logic [SW-1:0] secs(input int t);
    return SW'(t - 1);
  endfunction

  assign tick = div == DIV_LAST;
  assign expire = tick && sec_left == '0;
  assign half = div < DIV_HALF;
  // sync[1:0] is the 2-FF synchronizer, sync[2] the edge-detect delay
  assign rise = sync[1] & ~sync[2];
  assign ped_set = rise && state != S_PEDWALK;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_RESET;
      div <= '0;
      sec_left <= secs(T_RESET);
      cur_phase <= '0;
      req_pending <= 1'b0;
      sync <= '0;
    end else begin
      sync <= {sync[1:0], ped_req};
      div <= tick ? '0 : div + DW'(1);
      if (ped_set)
        req_pending <= 1'b1;
      if (state == S_FLASH) begin
        if (tick && !flash_en) begin
          state <= S_ALLRED;
          cur_phase <= LAST_PH;
          sec_left <= secs(T_ALLRED);
        end
      end else if (tick && sec_left != '0) begin
        sec_left <= sec_left - SW'(1);
      end else if (expire) begin
        unique case (state)
          S_RESET: begin
            state <= S_GREEN;
            cur_phase <= '0;
            sec_left <= secs(T_GREEN0);
          end
          S_GREEN: begin
            state <= S_YELLOW;
            sec_left <= secs(T_YELLOW);
          end
          S_YELLOW: begin
            state <= S_ALLRED;
            sec_left <= secs(T_ALLRED);
          end
          S_ALLRED: begin
            if (flash_en) begin
              state <= S_FLASH;
              sec_left <= '0;
            end else if (cur_phase < LAST_PH) begin
              state <= S_GREEN;
              cur_phase <= cur_phase + PW'(1);
              sec_left <= secs(T_GREEN);
            end else if (req_pending) begin
              // clear wins over a coincident set
              state <= S_PEDWALK;
              sec_left <= secs(T_PEDWALK);
              req_pending <= 1'b0;
            end else begin
              state <= S_GREEN;
              cur_phase <= '0;
              sec_left <= secs(T_GREEN0);
            end
          end
          S_PEDWALK: begin
            state <= S_PEDCLEAR;
            sec_left <= secs(T_PEDCLEAR);
          end
          S_PEDCLEAR: begin
            state <= S_GREEN;
            cur_phase <= '0;
            sec_left <= secs(T_GREEN0);
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NPHASES; i++)
      onehot[i] = cur_phase == PW'(i);
    phase_red = '1;
    phase_yellow = '0;
    phase_green = '0;
    ped_walk = 1'b0;
    ped_dontwalk = 1'b1;
    unique case (state)
      S_GREEN: begin
        phase_green = onehot;
        phase_red = ~onehot;
      end
      S_YELLOW: begin
        phase_yellow = onehot;
        phase_red = ~onehot;
      end
      S_PEDWALK: begin
        ped_walk = 1'b1;
        ped_dontwalk = 1'b0;
      end
      S_PEDCLEAR: ped_dontwalk = half;
      S_FLASH: begin
        phase_red = '0;
        phase_yellow = {NPHASES{half}};
        ped_dontwalk = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traffic_ctrl_n.sv
// tb_traffic_ctrl_n: scenario tasks plus randomized traffic, checked
// against a cycle-countdown model of the controller's rules.
module tb_traffic_ctrl_n;
  localparam int F = 4;
  localparam int N = 3;
  localparam int TRS = 2;
  localparam int TG0 = 3;
  localparam int TG = 3;
  localparam int TY = 2;
  localparam int TAR = 1;
  localparam int TPW = 5;
  localparam int TPC = 3;
  localparam int K_RS = 0, K_G = 1, K_Y = 2, K_AR = 3;
  localparam int K_PW = 4, K_PC = 5, K_FL = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ped_req = 1'b0;
  logic flash_en = 1'b0;
  logic [N-1:0] red, yel, grn;
  logic walk, dw, pend;
  logic [1:0] cur;
  logic [2:0] sec;
  int checks = 0;
  int failures = 0;

  traffic_ctrl_n #(
    .FPGAFREQ(F), .NPHASES(N), .T_GREEN(TG), .T_GREEN0(TG0),
    .T_YELLOW(TY), .T_ALLRED(TAR), .T_PEDWALK(TPW),
    .T_PEDCLEAR(TPC), .T_RESET(TRS)
  ) dut (
    .clk(clk), .reset(reset), .ped_req(ped_req), .flash_en(flash_en),
    .phase_red(red), .phase_yellow(yel), .phase_green(grn),
    .ped_walk(walk), .ped_dontwalk(dw), .req_pending(pend),
    .cur_phase(cur), .sec_left(sec)
  );

  always #5 clk = ~clk;

  // model: segment kind, phase, cycles left in segment, cycles since release
  int m_kind, m_ph, m_left, m_t;
  bit m_pend;
  bit [2:0] m_hist;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_kind = K_RS; m_ph = 0; m_left = TRS * F; m_t = 0;
      m_pend = 0; m_hist = 0;
    end else begin
      bit tk, rise;
      int nk;
      tk = (m_t % F) == F - 1;
      rise = m_hist[1] && !m_hist[2];
      m_hist = {m_hist[1:0], ped_req};
      nk = m_kind;
      if (m_kind == K_FL) begin
        if (tk && !flash_en) begin
          nk = K_AR; m_ph = N - 1; m_left = TAR * F;
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          case (m_kind)
            K_RS: begin nk = K_G; m_ph = 0; m_left = TG0 * F; end
            K_G: begin nk = K_Y; m_left = TY * F; end
            K_Y: begin nk = K_AR; m_left = TAR * F; end
            K_AR:
              if (flash_en) begin nk = K_FL; m_left = 1; end
              else if (m_ph < N - 1) begin
                nk = K_G; m_ph++; m_left = TG * F;
              end else if (m_pend) begin nk = K_PW; m_left = TPW * F; end
              else begin nk = K_G; m_ph = 0; m_left = TG0 * F; end
            K_PW: begin nk = K_PC; m_left = TPC * F; end
            K_PC: begin nk = K_G; m_ph = 0; m_left = TG0 * F; end
            default: ;
          endcase
        end
      end
      if (nk == K_PW && m_kind != K_PW) m_pend = 0;
      else if (rise && m_kind != K_PW) m_pend = 1;
      m_kind = nk;
      m_t++;
    end
  end

  logic [2:0] e_red, e_yel, e_grn, oh, e_sec;
  logic e_walk, e_dw, hf;
  logic [16:0] e_o, d_o;

  always_comb begin
    oh = 3'b001 << m_ph;
    hf = (m_t % F) < F / 2;
    e_red = 3'b111; e_yel = 3'b000; e_grn = 3'b000;
    e_walk = 1'b0; e_dw = 1'b1;
    case (m_kind)
      K_G: begin e_grn = oh; e_red = ~oh; end
      K_Y: begin e_yel = oh; e_red = ~oh; end
      K_PW: begin e_walk = 1'b1; e_dw = 1'b0; end
      K_PC: e_dw = hf;
      K_FL: begin e_red = 3'b000; e_yel = hf ? 3'b111 : 3'b000; e_dw = 1'b0; end
      default: ;
    endcase
    e_sec = (m_kind == K_FL) ? 3'd0 : 3'((m_left - 1) / F);
    e_o = {e_red, e_yel, e_grn, e_walk, e_dw, m_pend, 2'(m_ph), e_sec};
  end

  assign d_o = {red, yel, grn, walk, dw, pend, cur, sec};

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (red !== 3'b111) begin failures++; $display("FAIL rst_red got=%b exp=111", red); end
    checks++; if ({yel, grn} !== 6'b0) begin failures++; $display("FAIL rst_yg got=%b exp=0", {yel, grn}); end
    checks++; if ({walk, dw} !== 2'b01) begin failures++; $display("FAIL rst_ped got=%b exp=01", {walk, dw}); end
    checks++; if (pend !== 1'b0) begin failures++; $display("FAIL rst_pend got=%b exp=0", pend); end
    checks++; if (sec !== 3'(TRS - 1)) begin failures++; $display("FAIL rst_sec got=%0d exp=%0d", sec, TRS - 1); end
    checks++; if (cur !== 2'd0) begin failures++; $display("FAIL rst_cur got=%0d exp=0", cur); end
    reset = 1'b0;
  endtask

  task automatic test_powerup(input string nm);
    bit wseen = 0;
    for (int c = 1; c <= 84; c++) begin
      @(negedge clk);
      checks++; if (d_o !== e_o) begin failures++; $display("FAIL %s_model c=%0d got=%h exp=%h", nm, c, d_o, e_o); end
      wseen |= walk;
      if (c == 7) begin checks++; if (grn !== 3'b000) begin failures++; $display("FAIL %s_c7 got=%b exp=000", nm, grn); end end
      if (c == 8) begin checks++; if (grn !== 3'b001) begin failures++; $display("FAIL %s_c8 got=%b exp=001", nm, grn); end end
      if (c == 20) begin checks++; if (yel !== 3'b001) begin failures++; $display("FAIL %s_c20 got=%b exp=001", nm, yel); end end
      if (c == 28) begin checks++; if ({red, yel, grn} !== 9'b111_000_000) begin failures++; $display("FAIL %s_c28 got=%b exp=111000000", nm, {red, yel, grn}); end end
      if (c == 32) begin checks++; if (grn !== 3'b010) begin failures++; $display("FAIL %s_c32 got=%b exp=010", nm, grn); end end
      if (c == 80) begin checks++; if (grn !== 3'b001) begin failures++; $display("FAIL %s_c80 got=%b exp=001", nm, grn); end end
    end
    checks++; if (wseen !== 1'b0) begin failures++; $display("FAIL %s_nowalk got=%b exp=0", nm, wseen); end
  endtask

  task automatic test_ped();
    bit ok = 0;
    int n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      checks++; if (d_o !== e_o) begin failures++; $display("FAIL ped_model got=%h exp=%h", d_o, e_o); end
      if (grn === 3'b010) begin ok = 1; break; end
    end
    checks++; if (!ok) begin failures++; $display("FAIL ped_wait_g1 got=timeout exp=green1"); end
    ped_req = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (pend !== 1'b0) begin failures++; $display("FAIL ped_pend_early got=%b exp=0", pend); end
    ped_req = 1'b0;
    @(negedge clk);
    checks++; if (pend !== 1'b1) begin failures++; $display("FAIL ped_pend_set got=%b exp=1", pend); end
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      checks++; if (d_o !== e_o) begin failures++; $display("FAIL ped_model got=%h exp=%h", d_o, e_o); end
      if (walk === 1'b1) begin ok = 1; break; end
    end
    checks++; if (!ok) begin failures++; $display("FAIL ped_wait_walk got=timeout exp=walk"); end
    checks++; if (pend !== 1'b0) begin failures++; $display("FAIL ped_pend_clr got=%b exp=0", pend); end
    n = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++; if (d_o !== e_o) begin failures++; $display("FAIL ped_model got=%h exp=%h", d_o, e_o); end
      if (walk === 1'b1) n++; else break;
    end
    checks++; if (n != TPW * F) begin failures++; $display("FAIL ped_walk_len got=%0d exp=%0d", n, TPW * F); end
    for (int i = 0; i < TPC * F; i++) begin
      if (i > 0) @(negedge clk);
      checks++; if (dw !== ((i % 4) < 2)) begin failures++; $display("FAIL ped_blink i=%0d got=%b exp=%b", i, dw, (i % 4) < 2); end
    end
    @(negedge clk);
    checks++; if ({grn, dw, walk} !== 5'b001_1_0) begin failures++; $display("FAIL ped_back_g0 got=%b exp=00110", {grn, dw, walk}); end
  endtask

  task automatic test_walk_press();
    bit ok = 0;
    int nw = 0, np = 0;
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      checks++; if (d_o !== e_o) begin failures++; $display("FAIL wp_model got=%h exp=%h", d_o, e_o); end
      if (walk === 1'b1) begin ok = 1; break; end
    end
    checks++; if (!ok) begin failures++; $display("FAIL wp_wait_walk got=timeout exp=walk"); end
    nw = 1;
    for (int c = 1; c < 110; c++) begin
      @(negedge clk);
      checks++; if (d_o !== e_o) begin failures++; $display("FAIL wp_model c=%0d got=%h exp=%h", c, d_o, e_o); end
      nw += int'(walk);
      np += int'(pend);
      ped_req = (c >= 2 && c < 6);
    end
    checks++; if (np != 0) begin failures++; $display("FAIL wp_pend got=%0d exp=0", np); end
    checks++; if (nw != TPW * F) begin failures++; $display("FAIL wp_walk_cnt got=%0d exp=%0d", nw, TPW * F); end
  endtask

  task automatic test_flash();
    bit ok = 0, ar = 0;
    logic [5:0] prev;
    logic [1:0] pcur;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (grn === 3'b001) begin ok = 1; break; end
    end
    checks++; if (!ok) begin failures++; $display("FAIL fl_wait_g0 got=timeout exp=green0"); end
    flash_en = 1'b1;
    ok = 0;
    prev = {red, grn}; pcur = cur;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      checks++; if (d_o !== e_o) begin failures++; $display("FAIL fl_model got=%h exp=%h", d_o, e_o); end
      if (red === 3'b000) begin ok = 1; break; end
      prev = {red, grn}; pcur = cur;
    end
    checks++; if (!ok) begin failures++; $display("FAIL fl_enter got=timeout exp=flash"); end
    checks++; if ({prev, pcur} !== {6'b111_000, 2'd0}) begin failures++; $display("FAIL fl_after_ar0 got=%b exp=11100000", {prev, pcur}); end
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      checks++; if (yel !== (((i % 4) < 2) ? 3'b111 : 3'b000)) begin failures++; $display("FAIL fl_yel i=%0d got=%b", i, yel); end
      checks++; if ({red, grn, walk, dw, sec} !== 11'b0) begin failures++; $display("FAIL fl_dark got=%b exp=0", {red, grn, walk, dw, sec}); end
    end
    repeat ($urandom_range(0, 5)) @(negedge clk);
    flash_en = 1'b0;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++; if (d_o !== e_o) begin failures++; $display("FAIL fl_model got=%h exp=%h", d_o, e_o); end
      if (red === 3'b111) ar = 1;
      if (grn !== 3'b000) begin ok = 1; break; end
    end
    checks++; if (!ok || grn !== 3'b001 || !ar) begin failures++; $display("FAIL fl_exit got=%b ar=%b exp=001 ar=1", grn, ar); end
  endtask

  task automatic test_reset_walk();
    bit ok = 0;
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (walk === 1'b1) begin ok = 1; break; end
    end
    checks++; if (!ok) begin failures++; $display("FAIL rw_wait_walk got=timeout exp=walk"); end
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if ({red, yel, grn, walk, dw, pend} !== 12'b111_000_000_0_1_0) begin failures++; $display("FAIL rw_abort got=%b exp=111000000010", {red, yel, grn, walk, dw, pend}); end
    checks++; if ({cur, sec} !== {2'd0, 3'(TRS - 1)}) begin failures++; $display("FAIL rw_cnt got=%b exp=%b", {cur, sec}, {2'd0, 3'(TRS - 1)}); end
    @(negedge clk);
    reset = 1'b0;
    test_powerup("replay");
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      checks++; if (d_o !== e_o) begin failures++; $display("FAIL rand_model c=%0d got=%h exp=%h", c, d_o, e_o); end
      if ($urandom_range(0, 19) == 0) ped_req = ~ped_req;
      if ($urandom_range(0, 199) == 0) flash_en = ~flash_en;
      reset = ($urandom_range(0, 1499) == 0);
    end
    reset = 1'b0;
    flash_en = 1'b0;
    ped_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_powerup("powerup");
    test_ped();
    test_walk_press();
    test_flash();
    test_reset_walk();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
